// File: rtl/led_pkg.sv
// Shared encodings for the LED breathing sequencer: reported phase codes and internal FSM states.
package led_pkg;

    localparam logic [1:0] PH_OFF  = 2'd0;
    localparam logic [1:0] PH_RISE = 2'd1;
    localparam logic [1:0] PH_FALL = 2'd2;
    localparam logic [1:0] PH_HOLD = 2'd3;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_RISE    = 3'd1,
        S_FALL    = 3'd2,
        S_HOLD_HI = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

endpackage

// File: rtl/pwm_core.sv
// Tick-enabled PWM counter and comparator; flags the last tick of each period.
module pwm_core #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             tick_en,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm_out,
    output logic             period_done,
    output logic             boundary_c
);

    localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'((2 ** CNT_W) - 2);

    logic [CNT_W-1:0] pcnt;

    assign boundary_c = tick_en && (pcnt == PCNT_LAST);

    // Compare uses the pre-increment count so duty=DUTY_MAX stays high across the wrap.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            pcnt        <= '0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            period_done <= boundary_c;
            if (tick_en) begin
                pwm_out <= (pcnt < duty);
                pcnt    <= boundary_c ? '0 : pcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_breathe_pwm.sv
// Triangular breathing sequencer; duty and phase only change on PWM period boundaries.
module led_breathe_pwm
    import led_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned HOLD_PERIODS = 64
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             tick_en,
    input  logic             enable,
    output logic             pwm_out,
    output logic [CNT_W-1:0] duty,
    output logic [1:0]       phase,
    output logic             period_done
);

    localparam int unsigned MAX_PER = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
    localparam int unsigned PER_W   = $clog2(MAX_PER + 1);

    localparam logic [CNT_W-1:0] DUTY_MAX  = CNT_W'((2 ** CNT_W) - 1);
    localparam logic [PER_W-1:0] STEP_LAST = PER_W'(STEP_PERIODS - 1);
    localparam logic [PER_W-1:0] HOLD_LAST = PER_W'(HOLD_PERIODS - 1);

    state_t           state;
    logic [PER_W-1:0] per_cnt;
    logic             boundary_c;

    pwm_core #(.CNT_W(CNT_W)) u_core (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .tick_en    (tick_en),
        .duty       (duty),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .boundary_c (boundary_c)
    );

    // Disable wins over every step/hold transition; per_cnt restarts on each state change.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state   <= S_OFF;
            phase   <= PH_OFF;
            duty    <= '0;
            per_cnt <= '0;
        end else if (boundary_c) begin
            if (!enable) begin
                state   <= S_OFF;
                phase   <= PH_OFF;
                duty    <= '0;
                per_cnt <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        state   <= S_RISE;
                        phase   <= PH_RISE;
                        duty    <= '0;
                        per_cnt <= '0;
                    end
                    S_RISE: begin
                        if (per_cnt == STEP_LAST) begin
                            per_cnt <= '0;
                            if (duty != DUTY_MAX) duty <= duty + CNT_W'(1);
                            if (duty >= DUTY_MAX - CNT_W'(1)) begin
                                state <= S_HOLD_HI;
                                phase <= PH_HOLD;
                            end
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                    end
                    S_HOLD_HI: begin
                        if (per_cnt == HOLD_LAST) begin
                            per_cnt <= '0;
                            state   <= S_FALL;
                            phase   <= PH_FALL;
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                    end
                    S_FALL: begin
                        if (per_cnt == STEP_LAST) begin
                            per_cnt <= '0;
                            if (duty != '0) duty <= duty - CNT_W'(1);
                            if (duty <= CNT_W'(1)) begin
                                state <= S_HOLD_LO;
                                phase <= PH_HOLD;
                            end
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                    end
                    S_HOLD_LO: begin
                        if (per_cnt == HOLD_LAST) begin
                            per_cnt <= '0;
                            state   <= S_RISE;
                            phase   <= PH_RISE;
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                    end
                    default: begin
                        state   <= S_OFF;
                        phase   <= PH_OFF;
                        duty    <= '0;
                        per_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Randomized bench for led_breathe_pwm against a closed-form triangular-wave reference.
module tb_led_breathe_pwm;

    localparam int CNT_W = 4;
    localparam int STEP  = 1;
    localparam int HOLD  = 2;
    localparam int DM    = 15;
    localparam int RAMP  = DM * STEP;
    localparam int HALF  = RAMP + HOLD;
    localparam int CYC   = 2 * HALF;

    logic             CLOCK_50;
    logic             RESET;
    logic             tick_en;
    logic             enable;
    logic             pwm_out;
    logic [CNT_W-1:0] duty;
    logic [1:0]       phase;
    logic             period_done;

    led_breathe_pwm #(
        .CNT_W       (CNT_W),
        .STEP_PERIODS(STEP),
        .HOLD_PERIODS(HOLD)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .tick_en    (tick_en),
        .enable     (enable),
        .pwm_out    (pwm_out),
        .duty       (duty),
        .phase      (phase),
        .period_done(period_done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference state: position n along the breathing wave, counted in boundaries since RISE began.
    int m_pcnt = 0, m_n = 0, m_duty = 0, m_phase = 0, m_pwm = 0, m_pd = 0;
    bit m_on = 0;
    int per_duty = 0, hi_cnt = 0;
    bit cnt_valid = 0;
    bit gated = 0;
    int last_pd = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int wave_duty(input int n);
        if (n < RAMP) return n / STEP;
        if (n < HALF) return DM;
        if (n < HALF + RAMP) return DM - (n - HALF) / STEP;
        return 0;
    endfunction

    function automatic int wave_phase(input int n);
        if (n < RAMP) return 1;
        if (n < HALF) return 3;
        if (n < HALF + RAMP) return 2;
        return 3;
    endfunction

    task automatic step(input bit r, input bit t, input bit e);
        RESET   = r;
        tick_en = t;
        enable  = e;
        @(posedge CLOCK_50);
        cyc++;
        if (r) begin
            m_pcnt = 0; m_on = 0; m_n = 0; m_duty = 0; m_phase = 0; m_pwm = 0; m_pd = 0;
        end else begin
            m_pd = (t && m_pcnt == DM - 1) ? 1 : 0;
            if (t) begin
                m_pwm = (m_pcnt < m_duty) ? 1 : 0;
                if (m_pd == 1) begin
                    per_duty = m_duty;
                    if (!e) m_on = 0;
                    else if (!m_on) begin m_on = 1; m_n = 0; end
                    else m_n = (m_n + 1) % CYC;
                    m_duty  = m_on ? wave_duty(m_n) : 0;
                    m_phase = m_on ? wave_phase(m_n) : 0;
                end
                m_pcnt = (m_pcnt + 1) % DM;
            end
        end
        #1;
        chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
        chk("duty", 32'(duty), 32'(m_duty));
        chk("phase", 32'(phase), 32'(m_phase));
        chk("period_done", 32'(period_done), 32'(m_pd));
        if (r) begin
            hi_cnt = 0;
            cnt_valid = 0;
        end else begin
            if (t) hi_cnt += int'(pwm_out);
            if (m_pd == 1) begin
                if (cnt_valid) chk("high_per_period", 32'(hi_cnt), 32'(per_duty));
                hi_cnt = 0;
                cnt_valid = 1;
            end
        end
        if (gated && period_done) begin
            if (last_pd >= 0) chk("gated_period_len", 32'(cyc - last_pd), 32'd45);
            last_pd = cyc;
        end
    endtask

    initial begin
        bit found;
        bit en;
        RESET = 1'b1; tick_en = 1'b0; enable = 1'b0;

        repeat (3) step(1, 0, 0);
        repeat (40) step(0, 1, 0);

        // Full breathing waves with tick every cycle.
        repeat (2 * CYC * DM + 30) step(0, 1, 1);

        // Reset mid-run while enable stays high.
        repeat (3) step(1, 1, 1);
        repeat (100) step(0, 1, 1);

        // Drop enable mid-period at pcnt=5, duty=9.
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_duty == 9 && m_pcnt == 5) found = 1;
            else step(0, 1, 1);
        end
        chk("find_duty9_pcnt5", 32'(found), 32'd1);
        repeat (40) step(0, 1, 0);

        // Tick every third cycle.
        gated = 1;
        last_pd = -1;
        for (int i = 0; i < 1800; i++) step(0, (i % 3) == 2, 1);
        gated = 0;

        // Random ticks with rare enable toggles and resets.
        en = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) en = !en;
            step($urandom_range(0, 399) == 0, 1'($urandom_range(0, 1)), en);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
